// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD line engine.
// Receives 48-bit host command frames on cmd_i (one bit per sd_clk_en_i
// strobe), checks transmission bit, CRC7 and end bit, reports the command,
// then optionally answers with a 48-bit response frame after NcrCycles.
// Ports:
//   clk_i, rst_ni        system clock, async active-low reset
//   sd_clk_en_i          one-cycle strobe per SD bit period
//   cmd_i                CMD line as seen by the card
//   cmd_o, cmd_en_o      card drive value / output enable
//   cmd_valid_o, cmd_index_o, cmd_arg_o, cmd_err_o   received-command report
//   rsp_valid_i/rsp_ready_o, rsp_none_i, rsp_index_i, rsp_arg_i,
//   rsp_corrupt_i        response request handshake
//   timeout_o            pulse when a command is dropped unanswered
module sd_cmd_responder #(
    parameter int NcrCycles     = 2,
    parameter int MaxWaitCycles = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sd_clk_en_i,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_en_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        cmd_err_o,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic        rsp_none_i,
    input  logic [5:0]  rsp_index_i,
    input  logic [31:0] rsp_arg_i,
    input  logic        rsp_corrupt_i,
    output logic        timeout_o
);
    // Counter is shared by RX bit count (to 46), WAIT strobes and TX bits (47).
    localparam int WaitW = $clog2(MaxWaitCycles + 1);
    localparam int CntW  = (WaitW > 6) ? WaitW : 6;
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] NcrCnt = CntW'(NcrCycles);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWaitCycles);

    typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_e;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [47:0]     sr_q, sr_d;
    logic [6:0]      crc_q, crc_d;
    logic            err_q, err_d;
    logic            cmd_q, cmd_d, en_q, en_d;
    logic            vld_q, vld_d, cerr_q, cerr_d, to_q, to_d;
    logic [5:0]      idx_q, idx_d;
    logic [31:0]     arg_q, arg_d;
    logic            lat_q, lat_d, rnone_q, rnone_d, rcor_q, rcor_d;
    logic [5:0]      ridx_q, ridx_d;
    logic [31:0]     rarg_q, rarg_d;
    logic            hs;
    logic [39:0]     rsp_body;
    logic [47:0]     rsp_frame;

    assign rsp_ready_o = (state_q == WAIT) && !lat_q;
    assign hs          = rsp_valid_i && rsp_ready_o;
    assign rsp_body    = {2'b00, ridx_q, rarg_q};
    assign rsp_frame   = {rsp_body, crc7_40(rsp_body) ^ {7{rcor_q}}, 1'b1};

    assign cmd_en_o    = en_q;
    assign cmd_o       = en_q ? cmd_q : 1'b1;
    assign cmd_valid_o = vld_q;
    assign cmd_err_o   = cerr_q;
    assign cmd_index_o = idx_q;
    assign cmd_arg_o   = arg_q;
    assign timeout_o   = to_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        crc_d   = crc_q;
        err_d   = err_q;
        cmd_d   = cmd_q;
        en_d    = en_q;
        vld_d   = 1'b0;
        cerr_d  = cerr_q;
        to_d    = 1'b0;
        idx_d   = idx_q;
        arg_d   = arg_q;
        lat_d   = lat_q;
        rnone_d = rnone_q;
        rcor_d  = rcor_q;
        ridx_d  = ridx_q;
        rarg_d  = rarg_q;
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

        if (hs) begin
            lat_d   = 1'b1;
            rnone_d = rsp_none_i;
            rcor_d  = rsp_corrupt_i;
            ridx_d  = rsp_index_i;
            rarg_d  = rsp_arg_i;
        end

        if (sd_clk_en_i) begin
            unique case (state_q)
                IDLE: if (!cmd_i) begin
                    // Start bit is 0, so it leaves a zero CRC unchanged.
                    state_d = RX;
                    cnt_d   = '0;
                    crc_d   = '0;
                    err_d   = 1'b0;
                end
                RX: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q <= CntW'(38)) begin
                        // transmission bit, index, arg
                        if (cnt_q == '0) err_d = err_q | !cmd_i;
                        crc_d = crc7_step(crc_q, cmd_i);
                        sr_d  = {sr_q[46:0], cmd_i};
                    end else if (cnt_q <= CntW'(45)) begin
                        // compare received CRC against running CRC, MSB first
                        err_d = err_q | (cmd_i != crc_q[6]);
                        crc_d = {crc_q[5:0], 1'b0};
                    end else begin
                        vld_d   = 1'b1;
                        cerr_d  = err_q | !cmd_i;
                        idx_d   = sr_q[37:32];
                        arg_d   = sr_q[31:0];
                        cnt_d   = '0;
                        lat_d   = 1'b0;
                        state_d = (err_q | !cmd_i) ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    // cnt_inc = strobes since the end bit, including this one
                    cnt_d = cnt_inc;
                    if (lat_q && rnone_q) begin
                        lat_d   = 1'b0;
                        state_d = IDLE;
                    end else if (lat_q && cnt_inc >= NcrCnt) begin
                        lat_d   = 1'b0;
                        state_d = TX;
                        en_d    = 1'b1;
                        cmd_d   = rsp_frame[47];
                        sr_d    = {rsp_frame[46:0], 1'b0};
                        cnt_d   = CntW'(47);
                    end else if (!lat_q && !hs && cnt_inc >= MaxCnt) begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
                TX: begin
                    if (cnt_q != '0) begin
                        cmd_d = sr_q[47];
                        sr_d  = {sr_q[46:0], 1'b0};
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        en_d    = 1'b0;
                        cmd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            crc_q   <= '0;
            err_q   <= 1'b0;
            cmd_q   <= 1'b1;
            en_q    <= 1'b0;
            vld_q   <= 1'b0;
            cerr_q  <= 1'b0;
            to_q    <= 1'b0;
            idx_q   <= '0;
            arg_q   <= '0;
            lat_q   <= 1'b0;
            rnone_q <= 1'b0;
            rcor_q  <= 1'b0;
            ridx_q  <= '0;
            rarg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            vld_q   <= vld_d;
            cerr_q  <= cerr_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            lat_q   <= lat_d;
            rnone_q <= rnone_d;
            rcor_q  <= rcor_d;
            ridx_q  <= ridx_d;
            rarg_q  <= rarg_d;
        end
    end
endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: stimulus pushes expected command
// reports, timeouts and response frames; a negedge monitor pops and compares.
module tb_sd_cmd_responder;
    logic        clk = 1'b0, rst_ni = 1'b0, sd_clk_en_i = 1'b0, host_cmd = 1'b1;
    logic        cmd_line, cmd_o, cmd_en_o, cmd_valid_o, cmd_err_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic        rsp_valid_i, rsp_ready_o, rsp_none_i, rsp_corrupt_i, timeout_o;
    logic [5:0]  rsp_index_i;
    logic [31:0] rsp_arg_i;

    sd_cmd_responder #(.NcrCycles(2), .MaxWaitCycles(64)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .sd_clk_en_i(sd_clk_en_i), .cmd_i(cmd_line),
        .cmd_o(cmd_o), .cmd_en_o(cmd_en_o), .cmd_valid_o(cmd_valid_o),
        .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o), .cmd_err_o(cmd_err_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_none_i(rsp_none_i),
        .rsp_index_i(rsp_index_i), .rsp_arg_i(rsp_arg_i), .rsp_corrupt_i(rsp_corrupt_i),
        .timeout_o(timeout_o)
    );

    // Open-drain style CMD wire: card drive wins when enabled.
    assign cmd_line = cmd_en_o ? cmd_o : host_cmd;

    always #5 clk = ~clk;

    // One strobe every 4 clocks, changed just after posedge.
    initial forever begin
        repeat (3) @(posedge clk);
        #1 sd_clk_en_i = 1'b1;
        @(posedge clk);
        #1 sd_clk_en_i = 1'b0;
    end

    typedef struct packed { logic [5:0] idx; logic [31:0] arg; logic err; } cmd_exp_t;
    typedef struct packed { logic [47:0] frame; logic abort; } rsp_exp_t;
    cmd_exp_t exp_cmd[$];
    rsp_exp_t exp_rsp[$];
    int       exp_to[$];

    int checks = 0, failures = 0;
    int scnt = 0, end_s = 0, last_s = -1, nbits = 0, frames = 0, idle_bad = 0, tgap;
    logic [47:0] frame_cap = '0;
    logic        en_prev = 1'b0, cur_ok = 1'b0;
    rsp_exp_t    cur;
    cmd_exp_t    ce;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // CRC7 by polynomial long division (x^7+x^3+1 -> 0x89), zero initial value.
    function automatic logic [6:0] crc7m(input logic [39:0] m);
        logic [46:0] d;
        d = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
        return d[6:0];
    endfunction

    function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b;
        b = {2'b01, idx, arg};
        return {b, crc7m(b), 1'b1};
    endfunction

    function automatic logic [47:0] card_frame(input logic [5:0] idx, input logic [31:0] arg,
                                               input logic cor);
        logic [39:0] b;
        b = {2'b00, idx, arg};
        return {b, crc7m(b) ^ {7{cor}}, 1'b1};
    endfunction

    always @(posedge clk) if (sd_clk_en_i) scnt <= scnt + 1;

    // Monitor
    always @(negedge clk) begin
        if (cmd_valid_o) begin
            end_s = scnt;
            if (exp_cmd.size() == 0) chk("unexpected_cmd_valid", 1, 0);
            else begin
                ce = exp_cmd.pop_front();
                chk("cmd_index", cmd_index_o, ce.idx);
                chk("cmd_arg", cmd_arg_o, ce.arg);
                chk("cmd_err", cmd_err_o, ce.err);
            end
        end
        if (timeout_o) begin
            if (exp_to.size() == 0) chk("unexpected_timeout", 1, 0);
            else begin
                tgap = exp_to.pop_front();
                chk("timeout_strobe", scnt - end_s, tgap);
            end
        end
        if (!cmd_en_o && cmd_o !== 1'b1) idle_bad++;
        if (cmd_en_o && !en_prev) begin
            nbits = 0;
            frames++;
            frame_cap = '0;
            if (exp_rsp.size() == 0) begin
                chk("unexpected_cmd_en", 1, 0);
                cur_ok = 1'b0;
            end else begin
                cur = exp_rsp.pop_front();
                cur_ok = 1'b1;
                chk("rsp_ncr_gap", scnt - end_s, 2);
            end
        end
        if (cmd_en_o && scnt != last_s) begin
            frame_cap = {frame_cap[46:0], cmd_o};
            nbits++;
            last_s = scnt;
        end
        if (!cmd_en_o && en_prev && cur_ok) begin
            chk("rsp_complete", nbits == 48, !cur.abort);
            if (!cur.abort) chk("rsp_frame", frame_cap, cur.frame);
            cur_ok = 1'b0;
        end
        en_prev = cmd_en_o;
    end

    task automatic host_bit(input logic b);
        host_cmd = b;
        do @(posedge clk); while (!sd_clk_en_i);
        #1;
    endtask

    task automatic idle_strobes(input int n);
        repeat (n) host_bit(1'b1);
    endtask

    task automatic send_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) host_bit(f[i]);
        host_cmd = 1'b1;
    endtask

    task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic err);
        exp_cmd.push_back({idx, arg, err});
    endtask

    task automatic rsp_give(input logic none, input logic [5:0] idx, input logic [31:0] arg,
                            input logic cor);
        int n;
        n = 0;
        rsp_none_i = none; rsp_index_i = idx; rsp_arg_i = arg; rsp_corrupt_i = cor;
        rsp_valid_i = 1'b1;
        do begin @(negedge clk); n++; end while (!rsp_ready_o && n < 200);
        chk("rsp_ready_seen", rsp_ready_o, 1);
        @(posedge clk);
        #1;
        rsp_valid_i = 1'b0;
        chk("rsp_ready_drop", rsp_ready_o, 0);
    endtask

    initial begin
        int bad, n, fs;
        rsp_valid_i = 0; rsp_none_i = 0; rsp_index_i = 0; rsp_arg_i = 0; rsp_corrupt_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_o", cmd_o, 1);
        chk("rst_cmd_en", cmd_en_o, 0);
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_err", cmd_err_o, 0);
        chk("rst_ready", rsp_ready_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_index", cmd_index_o, 0);
        chk("rst_arg", cmd_arg_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        idle_strobes(3);

        // CMD0, no response requested
        push_cmd(6'd0, 32'd0, 1'b0);
        send_cmd(48'h40_0000_0000_95);
        rsp_give(1'b1, 6'd0, 32'd0, 1'b0);
        idle_strobes(6);

        // CMD12 with response index 12 arg 0x7A
        push_cmd(6'd12, 32'd0, 1'b0);
        exp_rsp.push_back({card_frame(6'd12, 32'h7A, 1'b0), 1'b0});
        send_cmd(host_frame(6'd12, 32'd0));
        rsp_give(1'b0, 6'd12, 32'h7A, 1'b0);
        idle_strobes(55);

        // CMD0 with bad CRC byte: reported as error, never answered
        push_cmd(6'd0, 32'd0, 1'b1);
        send_cmd(48'h40_0000_0000_97);
        bad = 0;
        repeat (300) @(negedge clk) if (rsp_ready_o || cmd_en_o) bad++;
        chk("badcrc_quiet", bad, 0);

        // good CMD0 left unanswered -> timeout at strobe 64
        push_cmd(6'd0, 32'd0, 1'b0);
        exp_to.push_back(64);
        send_cmd(48'h40_0000_0000_95);
        idle_strobes(70);

        // next command still accepted; corrupted CRC in the response
        push_cmd(6'd12, 32'd0, 1'b0);
        exp_rsp.push_back({card_frame(6'd12, 32'h7A, 1'b1), 1'b0});
        send_cmd(host_frame(6'd12, 32'd0));
        rsp_give(1'b0, 6'd12, 32'h7A, 1'b1);
        idle_strobes(55);

        // reset asserted while response bit 20 is on the line
        push_cmd(6'd12, 32'd0, 1'b0);
        exp_rsp.push_back({card_frame(6'd12, 32'h7A, 1'b0), 1'b1});
        fs = frames;
        send_cmd(host_frame(6'd12, 32'd0));
        rsp_give(1'b0, 6'd12, 32'h7A, 1'b0);
        n = 0;
        while (!(frames > fs && nbits >= 21) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("tx_reached_bit20", (frames > fs && nbits >= 21), 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_tx_cmd_en", cmd_en_o, 0);
        chk("rst_mid_tx_cmd_o", cmd_o, 1);
        chk("rst_mid_tx_index", cmd_index_o, 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        idle_strobes(4);
        push_cmd(6'd0, 32'd0, 1'b0);
        send_cmd(48'h40_0000_0000_95);
        rsp_give(1'b1, 6'd0, 32'd0, 1'b0);
        idle_strobes(60);

        chk("exp_cmd_drained", exp_cmd.size(), 0);
        chk("exp_rsp_drained", exp_rsp.size(), 0);
        chk("exp_timeout_drained", exp_to.size(), 0);
        chk("cmd_o_high_when_released", idle_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 SHALL have parameter NcrCycles, default 2, meaning minimum SD-clock strobes between command end bit and response start bit (legal 2..63).
REQ-002 SHALL have parameter MaxWaitCycles, default 64, meaning strobes after command end bit after which an unanswered command is dropped (legal > NcrCycles).
REQ-003 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sd_clk_en_i  input  1  one-cycle strobe marking one SD bit period; CMD sampled or shifted only on strobe cycles.
REQ-006 SHALL have port cmd_i  input  1  CMD line as seen by card (host drive or pull-up).
REQ-007 SHALL have port cmd_o  output  1  card CMD drive value.
REQ-008 SHALL have port cmd_en_o  output  1  card CMD output enable.
REQ-009 SHALL have ports cmd_valid_o  output 1; cmd_index_o  output 6; cmd_arg_o  output 32; cmd_err_o  output 1: received-command report.
REQ-010 SHALL have ports rsp_valid_i  input 1; rsp_ready_o  output 1; rsp_none_i  input 1; rsp_index_i  input 6; rsp_arg_i  input 32; rsp_corrupt_i  input 1: response request.
REQ-011 SHALL have port timeout_o  output 1  one-cycle pulse when a command is dropped unanswered.

Function
REQ-012 SHALL implement states IDLE, RX, WAIT, TX; all state transitions occur only on strobe cycles except the rsp handshake, which is accepted on any clk_i cycle.
REQ-013 SHALL, in IDLE, on a strobe with cmd_i=0, enter RX and count that sample as the start bit.
REQ-014 SHALL, in RX, shift in the next 47 strobe samples: transmission bit, index[5:0], arg[31:0] MSB first, CRC7, end bit.
REQ-015 SHALL compute CRC7 (polynomial x^7+x^3+1, initial value 0) over the 40 bits from start bit to arg LSB.
REQ-016 SHALL flag error if transmission bit != 1, CRC7 mismatch, or end bit != 1.
REQ-017 SHALL pulse cmd_valid_o for exactly one clk_i cycle, on the cycle after the end-bit strobe, with cmd_index_o/cmd_arg_o held stable until the next cmd_valid_o and cmd_err_o valid with the pulse.
REQ-018 SHALL, on error, return to IDLE and never assert rsp_ready_o or cmd_en_o for that command.
REQ-019 SHALL, on a good command, enter WAIT with strobe counter cleared; rsp_ready_o=1 only in WAIT while no response is latched.
REQ-020 SHALL latch rsp_* when rsp_valid_i and rsp_ready_o are both 1; rsp_ready_o drops the next cycle.
REQ-021 SHALL, if the latched rsp_none_i=1, return to IDLE without driving CMD.
REQ-022 SHALL begin TX on the first strobe where a response is latched and counter >= NcrCycles; a response latched earlier waits; rsp_valid_i asserted together with counter reaching NcrCycles starts TX on the next strobe.
REQ-023 SHALL, in TX, drive 48 bits, one per strobe, updating cmd_o on the strobe cycle: 0, 0, index, arg, CRC7 computed as in REQ-015, 1; CRC7 bitwise inverted when latched rsp_corrupt_i=1.
REQ-024 SHALL keep cmd_en_o=1 from the start-bit strobe until the strobe after the end bit, then cmd_en_o=0 and return to IDLE, ignoring cmd_i throughout TX.
REQ-025 SHALL, in WAIT with no response latched when counter reaches MaxWaitCycles, pulse timeout_o and return to IDLE.
REQ-026 SHALL drive cmd_o=1 whenever cmd_en_o=0.
REQ-027 SHALL use a saturating strobe counter wide enough for MaxWaitCycles.

Reset
REQ-028 SHALL, while rst_ni=0, force state IDLE, cmd_o=1, cmd_en_o=0, cmd_valid_o=0, cmd_err_o=0, rsp_ready_o=0, timeout_o=0, cmd_index_o=0, cmd_arg_o=0, and discard any latched response.
REQ-029 SHALL release CMD (cmd_en_o=0) asynchronously on reset assertion mid-TX, with no partial frame resumed after release.

Verification
REQ-030 SHALL cover: host sends CMD0 arg 0 (frame 0x40_00000000_95) -> cmd_valid_o pulse, index 0, arg 0, cmd_err_o=0; rsp_none_i=1 -> no cmd_en_o.
REQ-031 SHALL cover: CMD12 good frame, rsp index 12 arg 0x0000007A at NcrCycles=2 -> start bit exactly 2 strobes after end bit; bench decodes 48 bits, CRC7 matches model.
REQ-032 SHALL cover: CMD0 frame with CRC byte 0x97 -> cmd_err_o=1, rsp_ready_o never 1, cmd_en_o stays 0.
REQ-033 SHALL cover: good command, no rsp_valid_i -> timeout_o pulse at strobe 64, IDLE, next command accepted.
REQ-034 SHALL cover: rsp_corrupt_i=1 on CMD12 response -> CRC7 field equals inverted model CRC, end bit 1.
REQ-035 SHALL cover: rst_ni low at TX bit 20 -> cmd_en_o=0 same cycle; after release, fresh CMD0 decoded correctly.
